// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Program sequencer for the autoencoder datapath. Fetches fixed-format
// instructions from a synchronous instruction memory, presents the opcode and
// operand fields to the combinational control unit, honours a datapath stall
// and reports program completion to the host FSM.
//
// Instruction format: [15:12] op, [11:8] dst, [7:4] src1, [3:0] src2.
// LOOP (optional) reuses [11:4] as an iteration count and [3:0] as a backward
// branch distance.
//
// Optional feature macro: SEQ_LOOP_EN
//   defined   - opcode 1101 is LOOP (single level, non-nested hardware loop)
//   undefined - opcode 1101 is illegal and no loop registers are built
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   begin execution at prog_base (only sampled in IDLE)
//   prog_base    in   first instruction address
//   stall        in   datapath busy, extends EXEC while high
//   imem_addr    out  registered instruction memory address
//   imem_rdata   in   instruction word, valid one cycle after imem_addr
//   opcode       out  opcode to the control unit, NOP (all ones) outside EXEC
//   dst_addr     out  destination register field of the current instruction
//   src1_addr    out  first source register field
//   src2_addr    out  second source register field
//   instr_valid  out  commit strobe, one cycle per executed instruction
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse on HALT or illegal-opcode abort
//   err          out  sticky illegal-opcode flag, cleared by accepted start
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int unsigned PC_WIDTH       = 8,
    parameter int unsigned INSTR_WIDTH    = 16,
    parameter int unsigned OP_WIDTH       = 4,
    parameter int unsigned REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [PC_WIDTH-1:0]       prog_base,
    input  logic                      stall,
    output logic [PC_WIDTH-1:0]       imem_addr,
    input  logic [INSTR_WIDTH-1:0]    imem_rdata,
    output logic [OP_WIDTH-1:0]       opcode,
    output logic [REG_ADDR_WIDTH-1:0] dst_addr,
    output logic [REG_ADDR_WIDTH-1:0] src1_addr,
    output logic [REG_ADDR_WIDTH-1:0] src2_addr,
    output logic                      instr_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    // Field positions within the instruction word.
    localparam int unsigned OpLsb   = INSTR_WIDTH - OP_WIDTH;
    localparam int unsigned DstLsb  = 2 * REG_ADDR_WIDTH;
    localparam int unsigned Src1Lsb = REG_ADDR_WIDTH;
    localparam int unsigned Src2Lsb = 0;

    localparam logic [OP_WIDTH-1:0] OpNop      = '1;
    localparam logic [OP_WIDTH-1:0] OpHalt     = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] OpIllegalLo = OP_WIDTH'(8);
`ifdef SEQ_LOOP_EN
    localparam logic [OP_WIDTH-1:0] OpLoop     = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] OpIllegalHi = OP_WIDTH'(12);
    localparam int unsigned         CntWidth   = 2 * REG_ADDR_WIDTH;
`else
    localparam logic [OP_WIDTH-1:0] OpIllegalHi = OP_WIDTH'(13);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StExec,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [PC_WIDTH-1:0]      imem_addr_q, imem_addr_d;
    logic [INSTR_WIDTH-1:0]   ir_q, ir_d;
    logic                     instr_valid_q, instr_valid_d;
    logic                     err_q, err_d;

`ifdef SEQ_LOOP_EN
    logic                     loop_active_q, loop_active_d;
    logic [PC_WIDTH-1:0]      loop_pc_q, loop_pc_d;
    logic [CntWidth-1:0]      loop_rem_q, loop_rem_d;
    logic [CntWidth-1:0]      rd_cnt;
    logic [PC_WIDTH-1:0]      rd_back;
`endif

    logic [OP_WIDTH-1:0]      rd_op;
    logic                     rd_illegal;

    // Decode of the word arriving from memory during LATCH.
    always_comb begin
        rd_op      = imem_rdata[OpLsb +: OP_WIDTH];
        rd_illegal = (rd_op >= OpIllegalLo) && (rd_op <= OpIllegalHi);
`ifdef SEQ_LOOP_EN
        rd_cnt     = imem_rdata[Src1Lsb +: CntWidth];
        rd_back    = PC_WIDTH'(imem_rdata[Src2Lsb +: REG_ADDR_WIDTH]);
`endif
    end

    // Next-state logic. imem_addr is loaded with the target pc on every
    // transition into FETCH so the memory sees the address during FETCH and
    // the word is ready to capture at the end of LATCH.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        imem_addr_d   = imem_addr_q;
        ir_d          = ir_q;
        instr_valid_d = 1'b0;
        err_d         = err_q;
`ifdef SEQ_LOOP_EN
        loop_active_d = loop_active_q;
        loop_pc_d     = loop_pc_q;
        loop_rem_d    = loop_rem_q;
`endif

        case (state_q)
            StIdle: begin
                if (start) begin
                    pc_d        = prog_base;
                    imem_addr_d = prog_base;
                    err_d       = 1'b0;
                    state_d     = StFetch;
                end
            end

            StFetch: begin
                state_d = StLatch;
            end

            StLatch: begin
                ir_d = imem_rdata;
                if (rd_op == OpHalt) begin
                    state_d = StDone;
`ifdef SEQ_LOOP_EN
                    loop_active_d = 1'b0;
`endif
                end else if (rd_illegal) begin
                    err_d   = 1'b1;
                    state_d = StDone;
`ifdef SEQ_LOOP_EN
                    loop_active_d = 1'b0;
                end else if (rd_op == OpLoop) begin
                    state_d = StFetch;
                    if (!loop_active_q) begin
                        if (rd_cnt == '0) begin
                            pc_d = pc_q + PC_WIDTH'(1);
                        end else begin
                            loop_active_d = 1'b1;
                            loop_pc_d     = pc_q;
                            loop_rem_d    = rd_cnt - CntWidth'(1);
                            pc_d          = pc_q - rd_back;
                        end
                    end else if (pc_q == loop_pc_q) begin
                        if (loop_rem_q == '0) begin
                            loop_active_d = 1'b0;
                            pc_d          = pc_q + PC_WIDTH'(1);
                        end else begin
                            loop_rem_d = loop_rem_q - CntWidth'(1);
                            pc_d       = pc_q - rd_back;
                        end
                    end else begin
                        // A different LOOP while one is active is a nested
                        // loop, which the single set of loop registers
                        // cannot track.
                        err_d         = 1'b1;
                        loop_active_d = 1'b0;
                        state_d       = StDone;
                    end
                    imem_addr_d = pc_d;
`endif
                end else begin
                    state_d = StExec;
                end
            end

            StExec: begin
                if (!stall) begin
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + PC_WIDTH'(1);
                    imem_addr_d   = pc_q + PC_WIDTH'(1);
                    state_d       = StFetch;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            imem_addr_q   <= '0;
            ir_q          <= '0;
            instr_valid_q <= 1'b0;
            err_q         <= 1'b0;
`ifdef SEQ_LOOP_EN
            loop_active_q <= 1'b0;
            loop_pc_q     <= '0;
            loop_rem_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_addr_q   <= imem_addr_d;
            ir_q          <= ir_d;
            instr_valid_q <= instr_valid_d;
            err_q         <= err_d;
`ifdef SEQ_LOOP_EN
            loop_active_q <= loop_active_d;
            loop_pc_q     <= loop_pc_d;
            loop_rem_q    <= loop_rem_d;
`endif
        end
    end

    // Outputs. instr_valid is registered, so the commit strobe appears in the
    // cycle after the EXEC cycle that released the instruction.
    always_comb begin
        opcode      = (state_q == StExec) ? ir_q[OpLsb +: OP_WIDTH] : OpNop;
        dst_addr    = ir_q[DstLsb +: REG_ADDR_WIDTH];
        src1_addr   = ir_q[Src1Lsb +: REG_ADDR_WIDTH];
        src2_addr   = ir_q[Src2Lsb +: REG_ADDR_WIDTH];
        imem_addr   = imem_addr_q;
        instr_valid = instr_valid_q;
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
        err         = err_q;
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a per-cycle trace table for the
// basic program plus hand-written multi-cycle sequences.
module tb_instr_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  prog_base;
    logic        stall;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [3:0]  opcode;
    logic [3:0]  dst_addr;
    logic [3:0]  src1_addr;
    logic [3:0]  src2_addr;
    logic        instr_valid;
    logic        busy;
    logic        done;
    logic        err;

    instr_sequencer #(
        .PC_WIDTH       (8),
        .INSTR_WIDTH    (16),
        .OP_WIDTH       (4),
        .REG_ADDR_WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_base   (prog_base),
        .stall       (stall),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .opcode      (opcode),
        .dst_addr    (dst_addr),
        .src1_addr   (src1_addr),
        .src2_addr   (src2_addr),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: one cycle read latency.
    logic [15:0] mem [0:255];
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] op;
        logic       vld;
        logic       bsy;
        logic       dn;
        logic [7:0] addr;
        logic [3:0] dst;
    } trace_t;

    trace_t tr [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start at the current cycle (cycle 0) and runs until done or a
    // cycle budget expires (dc stays -1 then). Ends one cycle after done.
    task automatic run_prog(input logic [7:0] base, output int nv, output int dc,
                            output logic e1, output logic ed, output logic [7:0] ad);
        nv = 0;
        dc = -1;
        e1 = 1'bx;
        ed = 1'bx;
        ad = 'x;
        start = 1'b1;
        prog_base = base;
        for (int c = 0; c < 200; c++) begin
            if (c > 0) tick();
            if (c == 1) begin
                start = 1'b0;
                e1 = err;
            end
            if (instr_valid) nv++;
            if (done) begin
                dc = c;
                ed = err;
                ad = imem_addr;
                break;
            end
        end
        start = 1'b0;
        tick();
    endtask

    int         nv, dc;
    logic       e1, ed;
    logic [7:0] ad;
    int         exp_nv, exp_dc;
    logic       exp_err;
    logic [7:0] exp_ad;
    logic [3:0] exp_op;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        prog_base = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
        // Basic program: ADD d1 s2 s3, MUL d4 s5 s6, HALT.
        mem[8'h10] = 16'h0123;
        mem[8'h11] = 16'h2456;
        mem[8'h12] = 16'hE000;
        // Illegal opcode 1010.
        mem[8'h20] = 16'hA000;
        // Loop program: two body ops, LOOP cnt=3 back=2, HALT.
        mem[8'h30] = 16'h0123;
        mem[8'h31] = 16'h2456;
        mem[8'h32] = 16'hD032;
        mem[8'h33] = 16'hE000;
        // Sigmoid op for the mid-EXEC reset.
        mem[8'h40] = 16'h5789;

        //              op     vld   bsy   dn    addr   dst
        tr[0]  = '{4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0};
        tr[1]  = '{4'hF, 1'b0, 1'b1, 1'b0, 8'h10, 4'h0};
        tr[2]  = '{4'hF, 1'b0, 1'b1, 1'b0, 8'h10, 4'h0};
        tr[3]  = '{4'h0, 1'b0, 1'b1, 1'b0, 8'h10, 4'h1};
        tr[4]  = '{4'hF, 1'b1, 1'b1, 1'b0, 8'h11, 4'h1};
        tr[5]  = '{4'hF, 1'b0, 1'b1, 1'b0, 8'h11, 4'h1};
        tr[6]  = '{4'h2, 1'b0, 1'b1, 1'b0, 8'h11, 4'h4};
        tr[7]  = '{4'hF, 1'b1, 1'b1, 1'b0, 8'h12, 4'h4};
        tr[8]  = '{4'hF, 1'b0, 1'b1, 1'b0, 8'h12, 4'h4};
        tr[9]  = '{4'hF, 1'b0, 1'b1, 1'b1, 8'h12, 4'h0};
        tr[10] = '{4'hF, 1'b0, 1'b0, 1'b0, 8'h12, 4'h0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst opcode", opcode, 4'hF);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst err", err, 1'b0);
        check("rst valid", instr_valid, 1'b0);
        check("rst imem_addr", imem_addr, 8'h00);
        check("rst fields", {dst_addr, src1_addr, src2_addr}, 12'h000);
        rst = 1'b0;

        // Cycle-accurate trace of the basic program.
        start = 1'b1;
        prog_base = 8'h10;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) tick();
            if (c == 1) start = 1'b0;
            check($sformatf("trace c%0d opcode", c), opcode, tr[c].op);
            check($sformatf("trace c%0d valid", c), instr_valid, tr[c].vld);
            check($sformatf("trace c%0d busy", c), busy, tr[c].bsy);
            check($sformatf("trace c%0d done", c), done, tr[c].dn);
            check($sformatf("trace c%0d imem_addr", c), imem_addr, tr[c].addr);
            check($sformatf("trace c%0d dst", c), dst_addr, tr[c].dst);
            check($sformatf("trace c%0d err", c), err, 1'b0);
            if (c == 3) check("trace src fields", {src1_addr, src2_addr}, 8'h23);
        end

        // Stall held during the first EXEC (cycles 3..7), released at cycle 8.
        // stall is also high in cycles 0..2 where it must have no effect.
        start = 1'b1;
        prog_base = 8'h10;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) tick();
            if (c == 1) start = 1'b0;
            stall = (c < 8);
            exp_op = (c >= 3 && c <= 8) ? 4'h0 : (c == 11) ? 4'h2 : 4'hF;
            check($sformatf("stall c%0d opcode", c), opcode, exp_op);
            check($sformatf("stall c%0d valid", c), instr_valid, (c == 9 || c == 12));
            check($sformatf("stall c%0d done", c), done, (c == 14));
        end
        stall = 1'b0;

        // Illegal opcode aborts, then a new start clears err.
        run_prog(8'h20, nv, dc, e1, ed, ad);
        check("illegal valid count", nv, 0);
        check("illegal done cycle", dc, 3);
        check("illegal err at done", ed, 1'b1);
        check("illegal err sticky", err, 1'b1);
        check("illegal busy after", busy, 1'b0);
        run_prog(8'h10, nv, dc, e1, ed, ad);
        check("restart err cleared", e1, 1'b0);
        check("restart valid count", nv, 2);
        check("restart done cycle", dc, 9);

        // NOP at 0xFE, HALT at 0xFF.
        mem[8'hFE] = 16'hF000;
        mem[8'hFF] = 16'hE000;
        run_prog(8'hFE, nv, dc, e1, ed, ad);
        check("top valid count", nv, 1);
        check("top done cycle", dc, 6);
        check("top err", ed, 1'b0);
        check("top halt addr", ad, 8'hFF);

        // NOP at 0xFF, HALT at 0x00: pc wraps.
        mem[8'hFF] = 16'hF000;
        mem[8'h00] = 16'hE000;
        run_prog(8'hFF, nv, dc, e1, ed, ad);
        check("wrap valid count", nv, 1);
        check("wrap done cycle", dc, 6);
        check("wrap err", ed, 1'b0);
        check("wrap halt addr", ad, 8'h00);

        // Reset in the middle of a stalled sigmoid EXEC.
        stall = 1'b1;
        start = 1'b1;
        prog_base = 8'h40;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("sig opcode", opcode, 4'h5);
        check("sig dst", dst_addr, 4'h7);
        tick();
        check("sig opcode held", opcode, 4'h5);
        rst = 1'b1;
        tick();
        check("abort opcode", opcode, 4'hF);
        check("abort busy", busy, 1'b0);
        check("abort imem_addr", imem_addr, 8'h00);
        check("abort valid", instr_valid, 1'b0);
        check("abort dst", dst_addr, 4'h0);
        rst = 1'b0;
        stall = 1'b0;
        run_prog(8'h10, nv, dc, e1, ed, ad);
        check("post-abort valid count", nv, 2);
        check("post-abort done cycle", dc, 9);
        check("post-abort err", ed, 1'b0);

        // LOOP body of two ops, cnt=3: body runs four times.
`ifdef SEQ_LOOP_EN
        exp_nv = 8;
        exp_dc = 35;
        exp_err = 1'b0;
        exp_ad = 8'h33;
`else
        exp_nv = 2;
        exp_dc = 9;
        exp_err = 1'b1;
        exp_ad = 8'h32;
`endif
        run_prog(8'h30, nv, dc, e1, ed, ad);
        check("loop valid count", nv, exp_nv);
        check("loop done cycle", dc, exp_dc);
        check("loop err", ed, exp_err);
        check("loop end addr", ad, exp_ad);
        check("loop busy after", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program sequencer for the autoencoder datapath.
- Fetches 16-bit instructions from a synchronous instruction memory and presents the opcode to the combinational control unit, which decodes it into ALU, memory and activation-function enables.
- Presents register/memory addresses to the datapath, honours a datapath stall, and reports completion to the top-level host FSM.

Parameters:
- PC_WIDTH, 8, instruction memory address width; PC wraps modulo 2^PC_WIDTH.
- INSTR_WIDTH, 16, instruction word width; fixed format below.
- OP_WIDTH, 4, opcode width; matches the control unit.
- REG_ADDR_WIDTH, 4, width of each dst/src field.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin execution at prog_base; sampled only in IDLE.
- prog_base  input  PC_WIDTH  first instruction address, latched on start.
- stall  input  1  datapath busy; extends EXEC while high.
- imem_addr  output  PC_WIDTH  registered instruction memory address.
- imem_rdata  input  INSTR_WIDTH  instruction data, valid 1 cycle after imem_addr.
- opcode  output  OP_WIDTH  to control unit; 4'b1111 (NOP) outside EXEC.
- dst_addr, src1_addr, src2_addr  output  REG_ADDR_WIDTH each  operand fields of the current instruction.
- instr_valid  output  1  commit strobe, one cycle per executed instruction.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse on program end (HALT or abort).
- err  output  1  sticky illegal-opcode flag; cleared on accepted start or rst.

Behaviour:
- Reset (rst=1 at a clock edge, including mid-program):
  - state=IDLE; pc=0, imem_addr=0, opcode=4'b1111, all address fields 0.
  - instr_valid, busy, done, err=0; loop state cleared.
- Instruction format:
  - [15:12] op, [11:8] dst, [7:4] src1, [3:0] src2.
  - LOOP uses [11:4] cnt and [3:0] back instead of dst/src fields.
- Opcodes:
  - 0000-0111: datapath ops, forwarded to the control unit.
  - 1111: NOP, forwarded.
  - 1110: HALT.
  - 1101: LOOP (optional feature only).
  - 1000-1100: illegal.
- FSM:
  - IDLE: on start, pc<=prog_base, err<=0, go FETCH. start in any other state is ignored.
  - FETCH: imem_addr<=pc, go LATCH.
  - LATCH: capture imem_rdata into the instruction register. Then:
    - HALT: go DONE.
    - illegal: err<=1, go DONE.
    - LOOP: resolve per the optional feature, go FETCH.
    - otherwise: go EXEC.
  - EXEC: opcode and address fields driven from the instruction register.
    - While stall=1, hold.
    - On the first cycle with stall=0: instr_valid=1, pc<=pc+1, go FETCH.
  - DONE: done=1 for exactly one cycle, go IDLE. pc holds the HALT or illegal address for debug.
- Latency:
  - Unstalled non-LOOP instruction: 3 cycles (FETCH, LATCH, EXEC).
  - Each stall cycle adds one cycle.
  - start to first instr_valid: 4 cycles.
- opcode changes only on LATCH->EXEC and EXEC->FETCH edges, giving the control unit a stable code for the whole EXEC interval.
- PC wrap: an instruction at 2^PC_WIDTH-1 is followed by address 0, with no error.
- stall is ignored outside EXEC.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined — opcode 1101 is LOOP. Adds registers loop_active, loop_pc, loop_rem[7:0]. At LATCH:
  - !loop_active, cnt=0: pc<=pc+1.
  - !loop_active, cnt>0: loop_active<=1, loop_pc<=pc, loop_rem<=cnt-1, pc<=pc-back.
  - loop_active, pc==loop_pc, loop_rem=0: loop_active<=0, pc<=pc+1.
  - loop_active, pc==loop_pc, loop_rem>0: loop_rem<=loop_rem-1, pc<=pc-back.
  - loop_active, pc!=loop_pc: nested loop, treated as illegal (err, DONE).
  - Net effect: the body executes cnt+1 times.
  - LOOP never asserts instr_valid; opcode stays 1111.
  - HALT or abort clears loop_active.
- Undefined — 1101 is illegal; no loop registers exist.

Test Plan:
- Program at base 0x10: ADD(0000,d=1,s=2,3), MUL(0010), HALT. Pulse start, stall=0. Expect:
  - instr_valid at cycles 4 and 7 after start.
  - opcode 0000 then 0010 during EXEC; dst_addr=1 on the first.
  - done pulse at cycle 9.
  - busy low after done; err=0.
- Same program, stall high for 5 cycles during the first EXEC -> opcode held at 0000 throughout; instr_valid only once, on the stall-release cycle.
- Instruction 1010 at base -> err=1, done pulse, no instr_valid. A following start clears err.
- HALT at 0xFF preceded by NOP at 0xFE, program starting at 0xFE -> one instr_valid with opcode 1111, then done. Repeat with NOP at 0xFF and HALT at 0x00 to check wrap.
- rst asserted mid-EXEC of a sigmoid op (0101) -> next cycle opcode=1111, busy=0, imem_addr=0. A new start runs normally.
- SEQ_LOOP_EN: body of 2 ops followed by LOOP cnt=3, back=2 -> 8 instr_valid pulses, then the instruction after LOOP. Without the macro, the same program sets err.
